hamming_link_arbiter: RTL

- Shares one serial data/strobe line between 4 requesters using round-robin arbitration.
- Each granted 4-bit nibble is Hamming(7,4)-encoded and prefixed with a 2-bit source id. The resulting 9-bit frame is shifted out serially.
- Sits upstream of the error_inject / error_correct chain and feeds a single line in place of four parallel router lines.

---
 rtl/hamming_link_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/hamming_link_arbiter.sv
// rtl/hamming_link_arbiter.sv - round-robin arbiter serialising Hamming(7,4) frames from 4 requesters
// Optional feature macro: LINK_ERR_INJECT_EN (adds err_mask input and err_frames output).
module hamming_link_arbiter #(
    parameter int GAP_CYCLES = 1,
    parameter int INIT_PTR   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] d_in0,
    input  logic [3:0] d_in1,
    input  logic [3:0] d_in2,
    input  logic [3:0] d_in3,
`ifdef LINK_ERR_INJECT_EN
    input  logic [6:0] err_mask,
    output logic [7:0] err_frames,
`endif
    output logic [3:0] ack,
    output logic       data_out,
    output logic       strobe,
    output logic       busy,
    output logic [7:0] frame_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [3:0] LAST_BIT = 4'd8;
    localparam logic [3:0] LAST_GAP = 4'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [8:0]  shreg_q, shreg_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  ack_q, ack_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
`ifdef LINK_ERR_INJECT_EN
    logic        err_nz_q, err_nz_d;
    logic [7:0]  err_frames_q, err_frames_d;
`endif

    logic        grant_found;
    logic [1:0]  grant_idx;
    logic [1:0]  scan_idx;
    logic [3:0]  grant_nib;
    logic [6:0]  grant_code;

    // Codeword order c1..c7 = p1 p2 d1 p4 d2 d3 d4, with d1 the nibble MSB.
    function automatic logic [6:0] hamming74(input logic [3:0] d);
        logic p1, p2, p4;
        p1 = d[3] ^ d[2] ^ d[0];
        p2 = d[3] ^ d[1] ^ d[0];
        p4 = d[2] ^ d[1] ^ d[0];
        return {p1, p2, d[3], p4, d[2], d[1], d[0]};
    endfunction

    // Scan starts at the priority pointer; the 2-bit index wraps naturally.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = ptr_q;
        scan_idx    = ptr_q;
        for (int k = 0; k < 4; k++) begin
            scan_idx = ptr_q + 2'(k);
            if (!grant_found && req[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        grant_nib = d_in0;
        case (grant_idx)
            2'd0: grant_nib = d_in0;
            2'd1: grant_nib = d_in1;
            2'd2: grant_nib = d_in2;
            2'd3: grant_nib = d_in3;
            default: grant_nib = d_in0;
        endcase
    end

`ifdef LINK_ERR_INJECT_EN
    assign grant_code = hamming74(grant_nib) ^ err_mask;
`else
    assign grant_code = hamming74(grant_nib);
`endif

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        ack_d       = 4'b0000;
        frame_cnt_d = frame_cnt_q;
`ifdef LINK_ERR_INJECT_EN
        err_nz_d     = err_nz_q;
        err_frames_d = err_frames_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    state_d = ST_SHIFT;
                    shreg_d = {grant_idx, grant_code};
                    ack_d   = 4'b0001 << grant_idx;
                    ptr_d   = grant_idx + 2'd1;
                    cnt_d   = 4'd0;
`ifdef LINK_ERR_INJECT_EN
                    err_nz_d = |err_mask;
`endif
                end
            end
            ST_SHIFT: begin
                shreg_d = {shreg_q[7:0], 1'b0};
                if (cnt_q == LAST_BIT) begin
                    cnt_d       = 4'd0;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    state_d     = ST_GAP;
`ifdef LINK_ERR_INJECT_EN
                    if (err_nz_q) begin
                        err_frames_d = err_frames_q + 8'd1;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_GAP: begin
                if (cnt_q == LAST_GAP) begin
                    cnt_d   = 4'd0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 2'(INIT_PTR);
            shreg_q     <= 9'd0;
            cnt_q       <= 4'd0;
            ack_q       <= 4'd0;
            frame_cnt_q <= 8'd0;
`ifdef LINK_ERR_INJECT_EN
            err_nz_q     <= 1'b0;
            err_frames_q <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            ack_q       <= ack_d;
            frame_cnt_q <= frame_cnt_d;
`ifdef LINK_ERR_INJECT_EN
            err_nz_q     <= err_nz_d;
            err_frames_q <= err_frames_d;
`endif
        end
    end

    assign ack       = ack_q;
    assign strobe    = (state_q == ST_SHIFT);
    assign data_out  = (state_q == ST_SHIFT) & shreg_q[8];
    assign busy      = (state_q != ST_IDLE);
    assign frame_cnt = frame_cnt_q;
`ifdef LINK_ERR_INJECT_EN
    assign err_frames = err_frames_q;
`endif

endmodule
